// File: rtl/float_sum_seq.sv
// -----------------------------------------------------------------------------
// float_sum_seq
//
// Reduces a stream of `len` IEEE-754 single floats to one sum by driving an
// external pipelined float adder. Each accepted element produces exactly one
// adder request with the running accumulator on add_a and the element on
// add_b. The adder result becomes the new accumulator. After the last result
// the sum is published on `sum` with a one-cycle `done` pulse.
//
// No float arithmetic happens here. Sign, zero and normalisation handling
// belong entirely to the adder.
//
// Optional feature (macro FLOAT_SUM_SKIP_ZERO_EN):
//   When defined, an accepted element equal to +0.0 or -0.0 is consumed
//   without an adder request. The element count still decrements.
//   When undefined, every element goes through the adder.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-low reset
//   start     begin a reduction (sampled only while idle)
//   len       element count, sampled with start
//   in_valid  element valid
//   in_data   element
//   in_ready  element accepted when in_valid && in_ready
//   busy      high whenever not idle
//   done      one-cycle pulse, sum valid
//   sum       final sum, held until overwritten by the next result
//   add_req   one-cycle adder request
//   add_a     adder operand a (accumulator)
//   add_b     adder operand b (element)
//   add_out   adder result
//   add_ack   adder result valid (one cycle)
// -----------------------------------------------------------------------------
module float_sum_seq #(
  parameter int float_width = 32,
  parameter int len_width   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [len_width-1:0]   len,
  input  logic                   in_valid,
  input  logic [float_width-1:0] in_data,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   done,
  output logic [float_width-1:0] sum,
  output logic                   add_req,
  output logic [float_width-1:0] add_a,
  output logic [float_width-1:0] add_b,
  input  logic [float_width-1:0] add_out,
  input  logic                   add_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam logic [len_width-1:0]   LEN_ZERO = {len_width{1'b0}};
  localparam logic [len_width-1:0]   LEN_ONE  = {{(len_width-1){1'b0}}, 1'b1};
  localparam logic [float_width-1:0] F_ZERO   = {float_width{1'b0}};

  state_t                 state_r, state_s;
  logic [float_width-1:0] acc_r, acc_s;
  logic [float_width-1:0] sum_r, sum_s;
  logic [float_width-1:0] add_a_r, add_a_s;
  logic [float_width-1:0] add_b_r, add_b_s;
  logic [len_width-1:0]   rem_r, rem_s;
  logic                   done_r, done_s;
  logic                   add_req_r, add_req_s;
  logic                   skip_s;

  // Status outputs are pure state decodes; everything else comes from flops.
  assign in_ready = (state_r == WAIT_IN);
  assign busy     = (state_r != IDLE);
  assign done     = done_r;
  assign sum      = sum_r;
  assign add_req  = add_req_r;
  assign add_a    = add_a_r;
  assign add_b    = add_b_r;

  // Zero-element detection: exponent and mantissa both zero, sign ignored.
  always_comb begin
    skip_s = 1'b0;
`ifdef FLOAT_SUM_SKIP_ZERO_EN
    if (in_data[float_width-2:0] == F_ZERO[float_width-2:0]) begin
      skip_s = 1'b1;
    end else begin
      skip_s = 1'b0;
    end
`else
    skip_s = 1'b0;
`endif
  end

  // Next-state and next-output computation.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    sum_s     = sum_r;
    add_a_s   = add_a_r;
    add_b_s   = add_b_r;
    rem_s     = rem_r;
    done_s    = 1'b0;
    add_req_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len == LEN_ZERO) begin
            // Empty reduction completes immediately with +0.0.
            sum_s  = F_ZERO;
            done_s = 1'b1;
          end else begin
            acc_s   = F_ZERO;
            rem_s   = len;
            state_s = WAIT_IN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_IN: begin
        if (in_valid && skip_s) begin
          // Zero element: adding it cannot change the accumulator.
          rem_s = rem_r - LEN_ONE;
          if (rem_r == LEN_ONE) begin
            sum_s   = acc_r;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WAIT_IN;
          end
        end else if (in_valid) begin
          add_req_s = 1'b1;
          add_a_s   = acc_r;
          add_b_s   = in_data;
          state_s   = WAIT_ACK;
        end else begin
          state_s = WAIT_IN;
        end
      end
      WAIT_ACK: begin
        // Operands stay put until the adder answers, however long it takes.
        if (add_ack) begin
          acc_s = add_out;
          rem_s = rem_r - LEN_ONE;
          if (rem_r == LEN_ONE) begin
            sum_s   = add_out;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = WAIT_IN;
          end
        end else begin
          state_s = WAIT_ACK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      acc_r     <= F_ZERO;
      sum_r     <= F_ZERO;
      add_a_r   <= F_ZERO;
      add_b_r   <= F_ZERO;
      rem_r     <= LEN_ZERO;
      done_r    <= 1'b0;
      add_req_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      sum_r     <= sum_s;
      add_a_r   <= add_a_s;
      add_b_r   <= add_b_s;
      rem_r     <= rem_s;
      done_r    <= done_s;
      add_req_r <= add_req_s;
    end
  end

endmodule

// File: tb/tb_float_sum_seq.sv
// -----------------------------------------------------------------------------
// tb_float_sum_seq
//
// Directed bench for float_sum_seq. Contains a behavioural pipelined adder
// (real-number arithmetic, configurable latency), a transaction-level
// reference of the reduction that is compared against the DUT on every
// falling edge, and hand-computed sums for each scenario.
// -----------------------------------------------------------------------------
module tb_float_sum_seq;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        start    = 1'b0;
  logic [15:0] len      = 16'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data  = 32'd0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        add_req;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_out  = 32'd0;
  logic        add_ack  = 1'b0;

  int tests = 0;
  int fails = 0;

`ifdef FLOAT_SUM_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  float_sum_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .add_req  (add_req),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_out  (add_out),
    .add_ack  (add_ack)
  );

  always #5 clk = ~clk;

  // ---------------- float helpers (normal numbers and zero) ----------------
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {24'd0, f[30:23]} - 127;
    r = 1.0 + $itor({9'd0, f[22:0]}) / 8388608.0;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real x;
    int  e;
    int  m;
    logic s;
    if (r == 0.0) return 32'h00000000;
    s = (r < 0.0);
    x = s ? -r : r;
    e = 127;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    m = $rtoi((x - 1.0) * 8388608.0);
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- adder model state ----------------
  int          lat_min = 3;
  int          lat_max = 3;
  int          cnt     = 0;
  int          req_cnt = 0;
  int          spur_req  = 0;
  int          spur_done = 0;
  logic [31:0] res = 32'd0;
  logic [31:0] log_a[$];
  logic [31:0] log_b[$];

  // ---------------- reference model state ----------------
  int          ph = 0;      // 0 idle, 1 waiting element, 2 waiting result
  int          rem = 0;
  logic [31:0] acc = 32'd0;
  logic [31:0] exp_a = 32'd0;
  logic [31:0] exp_b = 32'd0;
  logic [31:0] exp_sum = 32'd0;
  logic        exp_done = 1'b0;
  logic        exp_req = 1'b0;

  logic [31:0] got_sum;
  int          r0;
  bit          hit;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [15:0] n);
    tick();
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] e, input int gap);
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = e;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (in_ready) hit = 1'b1;
    end
    check("accept_timeout", {31'd0, hit}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] s);
    hit = 1'b0;
    s   = 32'hDEADBEEF;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (done) begin hit = 1'b1; s = sum; end
    end
    check("done_timeout", {31'd0, hit}, 32'd1);
  endtask

  initial begin
    fork
      // Behavioural adder: result appears lat cycles after the request cycle.
      forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
          cnt     = 0;
          add_ack = 1'b0;
          add_out = 32'd0;
        end else begin
          add_ack = 1'b0;
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              add_ack = 1'b1;
              add_out = res;
            end
          end
          if (spur_req != spur_done) begin
            add_ack = 1'b1;
            add_out = 32'h41200000;
            spur_done++;
          end
          if (add_req) begin
            check("one_req_per_ack", cnt, 32'd0);
            req_cnt++;
            log_a.push_back(add_a);
            log_b.push_back(add_b);
            res = fp_add(add_a, add_b);
            cnt = $urandom_range(lat_max, lat_min);
          end
        end
      end
      // Reference comparison on every falling edge.
      forever begin
        @(negedge clk);
        if (!rst) begin
          check("rst_busy",     {31'd0, busy},     32'd0);
          check("rst_done",     {31'd0, done},     32'd0);
          check("rst_in_ready", {31'd0, in_ready}, 32'd0);
          check("rst_add_req",  {31'd0, add_req},  32'd0);
          check("rst_sum",   sum,   32'd0);
          check("rst_add_a", add_a, 32'd0);
          check("rst_add_b", add_b, 32'd0);
          ph = 0; exp_done = 1'b0; exp_req = 1'b0;
        end else begin
          check("busy",     {31'd0, busy},     {31'd0, (ph != 0)});
          check("in_ready", {31'd0, in_ready}, {31'd0, (ph == 1)});
          check("done",     {31'd0, done},     {31'd0, exp_done});
          check("add_req",  {31'd0, add_req},  {31'd0, exp_req});
          if (exp_done) check("sum", sum, exp_sum);
          if (ph == 2) begin
            check("add_a", add_a, exp_a);
            check("add_b", add_b, exp_b);
          end
          exp_done = 1'b0;
          exp_req  = 1'b0;
          if (ph == 0) begin
            if (start) begin
              if (len == 16'd0) begin
                exp_done = 1'b1;
                exp_sum  = 32'd0;
              end else begin
                ph = 1; rem = {16'd0, len}; acc = 32'd0;
              end
            end
          end else if (ph == 1) begin
            if (in_valid) begin
              if (SKIP && in_data[30:0] == 31'd0) begin
                rem--;
                if (rem == 0) begin
                  exp_done = 1'b1; exp_sum = acc; ph = 0;
                end
              end else begin
                exp_req = 1'b1; exp_a = acc; exp_b = in_data; ph = 2;
              end
            end
          end else begin
            if (add_ack) begin
              acc = fp_add(exp_a, exp_b);
              rem--;
              if (rem == 0) begin
                exp_done = 1'b1; exp_sum = acc; ph = 0;
              end else begin
                ph = 1;
              end
            end
          end
        end
      end
    join_none

    // Pin the float model with hand-computed values.
    check("model_1_plus_2",    fp_add(32'h3F800000, 32'h40000000), 32'h40400000);
    check("model_cancel",      fp_add(32'h3F800000, 32'hBF800000), 32'h00000000);
    check("model_half_half",   fp_add(32'h3F000000, 32'h3F000000), 32'h3F800000);
    check("model_3_plus_3",    fp_add(32'h40400000, 32'h40400000), 32'h40C00000);

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_sum",  sum,           32'd0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Basic sum 1+2+3.
    r0 = req_cnt;
    do_start(16'd3);
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    send(32'h40400000, 0);
    wait_done(got_sum);
    check("basic_sum", got_sum, 32'h40C00000);
    @(negedge clk);
    check("basic_busy_after_done", {31'd0, busy}, 32'd0);
    check("basic_req_count", req_cnt - r0, 32'd3);
    check("basic_first_a", log_a[r0], 32'h00000000);
    check("basic_first_b", log_b[r0], 32'h3F800000);

    // Zero length.
    r0 = req_cnt;
    do_start(16'd0);
    wait_done(got_sum);
    check("zero_len_sum", got_sum, 32'h00000000);
    repeat (3) tick();
    check("zero_len_req_count", req_cnt - r0, 32'd0);

    // Cancellation and ordering.
    r0 = req_cnt;
    do_start(16'd2);
    send(32'h3F800000, 1);
    send(32'hBF800000, 0);
    wait_done(got_sum);
    check("cancel_sum", got_sum, 32'h00000000);
    check("cancel_second_a", log_a[r0 + 1], 32'h3F800000);
    check("cancel_second_b", log_b[r0 + 1], 32'hBF800000);

    // Backpressure and variable adder latency.
    lat_min = 1;
    lat_max = 10;
    r0 = req_cnt;
    do_start(16'd4);
    for (int k = 0; k < 4; k++) send(32'h3F000000, $urandom_range(7, 0));
    wait_done(got_sum);
    check("bp_sum", got_sum, 32'h40000000);
    check("bp_req_count", req_cnt - r0, 32'd4);
    lat_min = 3;
    lat_max = 3;

    // Spurious ack in WAIT_IN and start while busy.
    do_start(16'd2);
    send(32'h3F800000, 0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (in_ready) hit = 1'b1;
    end
    check("spur_ready_timeout", {31'd0, hit}, 32'd1);
    tick();
    spur_req++;
    start = 1'b1;
    len   = 16'd5;
    tick();
    start = 1'b0;
    send(32'h40000000, 2);
    wait_done(got_sum);
    check("spur_sum", got_sum, 32'h40400000);
    repeat (3) tick();
    check("spur_idle_after", {31'd0, busy}, 32'd0);

    // Reset during WAIT_ACK, then a fresh single-element reduction.
    do_start(16'd2);
    send(32'h3F800000, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy",    {31'd0, busy},    32'd0);
    check("midrst_add_req", {31'd0, add_req}, 32'd0);
    check("midrst_add_a",   add_a,            32'd0);
    check("midrst_add_b",   add_b,            32'd0);
    check("midrst_sum",     sum,              32'd0);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    do_start(16'd1);
    send(32'h3FC00000, 0);
    wait_done(got_sum);
    check("midrst_new_sum", got_sum, 32'h3FC00000);

    // Zero elements: skipped when the feature is built in.
    r0 = req_cnt;
    do_start(16'd3);
    send(32'h00000000, 0);
    send(32'h80000000, 0);
    send(32'h3FC00000, 0);
    wait_done(got_sum);
    check("skipzero_sum", got_sum, 32'h3FC00000);
    check("skipzero_req_count", req_cnt - r0, SKIP ? 32'd1 : 32'd3);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
